// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - hex calculator operand builder with history recall and ALU handshake
module operand_entry #(
    parameter  int WIDTH      = 16,
    parameter  int DIGIT_W    = 4,
    parameter  bit EMPTY_OK   = 1'b0,
    localparam int MAX_DIGITS = WIDTH / DIGIT_W,
    localparam int CNT_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               backspace,
    input  logic               clear,
    input  logic               recall,
    input  logic [WIDTH-1:0]   recall_value,
    input  logic               commit,
    input  logic               op_ready,
    output logic               op_valid,
    output logic [WIDTH-1:0]   op_data,
    output logic [WIDTH-1:0]   entry_value,
    output logic [CNT_W-1:0]   digit_count,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_EDIT,
        S_RECALLED,
        S_PENDING
    } state_t;

    state_t state;

    // Single state machine: one action per cycle, clear > recall > backspace > digit > commit.
    // While PENDING only clear or the handshake can move the machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_EMPTY;
            entry_value <= '0;
            digit_count <= '0;
            op_valid    <= 1'b0;
            op_data     <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            state       <= S_EMPTY;
            entry_value <= '0;
            digit_count <= '0;
            op_valid    <= 1'b0;
            overflow    <= 1'b0;
        end else if (state == S_PENDING) begin
            if (op_ready) begin
                state       <= S_EMPTY;
                entry_value <= '0;
                digit_count <= '0;
                op_valid    <= 1'b0;
                overflow    <= 1'b0;
            end
        end else if (recall) begin
            state       <= S_RECALLED;
            entry_value <= recall_value;
            digit_count <= MAX_CNT;
            overflow    <= 1'b0;
        end else if (backspace) begin
            case (state)
                S_EDIT: begin
                    entry_value <= entry_value >> DIGIT_W;
                    digit_count <= digit_count - 1'b1;
                    overflow    <= 1'b0;
                    if (digit_count == CNT_W'(1)) begin
                        state <= S_EMPTY;
                    end
                end
                S_RECALLED: begin
                    state       <= S_EMPTY;
                    entry_value <= '0;
                    digit_count <= '0;
                end
                default: ;
            endcase
        end else if (digit_valid) begin
            if (state == S_EDIT) begin
                if (digit_count < MAX_CNT) begin
                    entry_value <= {entry_value[WIDTH-DIGIT_W-1:0], digit};
                    digit_count <= digit_count + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else begin
                // EMPTY or RECALLED: a typed digit starts a fresh entry
                state       <= S_EDIT;
                entry_value <= WIDTH'(digit);
                digit_count <= CNT_W'(1);
            end
        end else if (commit) begin
            if (state != S_EMPTY) begin
                state    <= S_PENDING;
                op_data  <= entry_value;
                op_valid <= 1'b1;
            end else if (EMPTY_OK) begin
                state    <= S_PENDING;
                op_data  <= '0;
                op_valid <= 1'b1;
            end
        end
    end

endmodule
